fofb_readout_scheduler: RTL and testbench

Sequences and shares the system-clock readout port of the FOFB link DPRAM (X/Y/S words per BPM index). On each FA cycle start it scans indices 0..bpmCount-1 and emits one X/Y/S beat per index to the correction pipeline. It also serves single-word processor reads, arbitrated round-robin against the scan. It sits in the sysClk domain and drives the DPRAM's `readoutAddress`, whose read data returns one clock later.

---
 rtl/fofb_readout_pkg.sv | 28 ++
 rtl/fofb_readout_scheduler_if.sv | 12 +
 rtl/fofb_readout_rr_arb.sv | 34 +++
 rtl/fofb_readout_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_fofb_readout_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fofb_readout_pkg.sv
// Shared types and constants for the FOFB DPRAM readout scheduler.
// The optional index mask lives behind the FOFB_READOUT_MASK_EN macro in the top level.
package fofb_readout_pkg;

    localparam int FOFB_INDEX_WIDTH = 9;
    localparam int TABLE_DEPTH      = 1 << FOFB_INDEX_WIDTH;
    localparam int READ_LATENCY     = 2;

    localparam logic [FOFB_INDEX_WIDTH:0] MAX_COUNT = (FOFB_INDEX_WIDTH + 1)'(TABLE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN
    } state_t;

    typedef enum logic {
        OWN_SCAN,
        OWN_CPU
    } owner_t;

    typedef struct packed {
        logic                        valid;
        owner_t                      owner;
        logic [FOFB_INDEX_WIDTH-1:0] index;
    } tag_t;

endpackage

// File: rtl/fofb_readout_scheduler_if.sv
// System-clock readout port of the FOFB link DPRAM: registered address out, X/Y/S data back one clock later.
interface fofb_readout_scheduler_if;

    logic [fofb_readout_pkg::FOFB_INDEX_WIDTH-1:0] readoutAddress;
    logic [31:0]                                   readoutX;
    logic [31:0]                                   readoutY;
    logic [31:0]                                   readoutS;

    modport master (output readoutAddress, input readoutX, readoutY, readoutS);
    modport slave  (input readoutAddress, output readoutX, readoutY, readoutS);

endinterface

// File: rtl/fofb_readout_rr_arb.sv
// Two-way round-robin arbiter; on contention the requester that did not win last time is granted.
module fofb_readout_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    // last_q records which requester won most recently (0 or 1)
    always_comb begin
        grant  = req;
        last_d = last_q;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
        if (grant[1]) begin
            last_d = 1'b1;
        end else if (grant[0]) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fofb_readout_scheduler.sv
// Shares the DPRAM readout port between the per-FA-cycle index scan and single-word processor reads.
// Define FOFB_READOUT_MASK_EN to add the bpmMask port and skip masked-off indices during a scan.
module fofb_readout_scheduler
    import fofb_readout_pkg::*;
(
    input  logic                          sysClk,
    input  logic                          sysReset,
    input  logic                          startStrobe,
    input  logic [FOFB_INDEX_WIDTH:0]     bpmCount,
`ifdef FOFB_READOUT_MASK_EN
    input  logic [TABLE_DEPTH-1:0]        bpmMask,
`endif
    fofb_readout_scheduler_if.master      dpram,
    output logic                          scanValid,
    output logic [FOFB_INDEX_WIDTH-1:0]   scanIndex,
    output logic [31:0]                   scanX,
    output logic [31:0]                   scanY,
    output logic [31:0]                   scanS,
    output logic                          scanBusy,
    output logic                          scanDone,
    input  logic                          cpuReq,
    input  logic [FOFB_INDEX_WIDTH-1:0]   cpuAddress,
    output logic                          cpuAck,
    output logic [31:0]                   cpuX,
    output logic [31:0]                   cpuY,
    output logic [31:0]                   cpuS,
    output logic                          cpuBusy,
    output logic [15:0]                   overrunCount
);

    typedef logic [FOFB_INDEX_WIDTH:0]   count_t;
    typedef logic [FOFB_INDEX_WIDTH-1:0] index_t;

    state_t      state_q, state_d;
    count_t      ptr_q, ptr_d;
    count_t      count_q, count_d;
    logic        cpu_pending_q, cpu_pending_d;
    logic        cpu_busy_q, cpu_busy_d;
    index_t      cpu_addr_q, cpu_addr_d;
    index_t      addr_q, addr_d;
    tag_t        tag_q [READ_LATENCY];
    tag_t        tag_d [READ_LATENCY];
    logic        scan_valid_q, scan_valid_d;
    index_t      scan_index_q, scan_index_d;
    logic [31:0] scan_x_q, scan_x_d, scan_y_q, scan_y_d, scan_s_q, scan_s_d;
    logic        scan_done_q, scan_done_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [31:0] cpu_x_q, cpu_x_d, cpu_y_q, cpu_y_d, cpu_s_q, cpu_s_d;
    logic [15:0] overrun_q, overrun_d;

    logic        scan_active;
    logic        index_enabled;
    logic        scan_req;
    logic        scan_skip;
    logic        scan_in_flight;
    logic [1:0]  grant;
    tag_t        exit_tag;

    assign scan_active = (state_q == S_SCAN) && (ptr_q < count_q);
`ifdef FOFB_READOUT_MASK_EN
    assign index_enabled = bpmMask[ptr_q[FOFB_INDEX_WIDTH-1:0]];
`else
    assign index_enabled = 1'b1;
`endif
    assign scan_req  = scan_active && index_enabled;
    assign scan_skip = scan_active && !index_enabled;
    assign exit_tag  = tag_q[READ_LATENCY-1];

    // Only scan tags hold up scan completion, so scanDone trails the last scan beat by one cycle.
    always_comb begin
        scan_in_flight = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            if (tag_q[i].valid && (tag_q[i].owner == OWN_SCAN)) begin
                scan_in_flight = 1'b1;
            end
        end
    end

    fofb_readout_rr_arb u_arb (
        .clk   (sysClk),
        .rst   (sysReset),
        .req   ({cpu_pending_q, scan_req}),
        .grant (grant)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        cpu_pending_d = cpu_pending_q;
        cpu_busy_d    = cpu_busy_q;
        cpu_addr_d    = cpu_addr_q;
        addr_d        = addr_q;
        scan_valid_d  = 1'b0;
        scan_index_d  = scan_index_q;
        scan_x_d      = scan_x_q;
        scan_y_d      = scan_y_q;
        scan_s_d      = scan_s_q;
        scan_done_d   = 1'b0;
        cpu_ack_d     = 1'b0;
        cpu_x_d       = cpu_x_q;
        cpu_y_d       = cpu_y_q;
        cpu_s_d       = cpu_s_q;
        overrun_d     = overrun_q;
        tag_d[0]      = '0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (startStrobe) begin
                    count_d = (bpmCount > MAX_COUNT) ? MAX_COUNT : bpmCount;
                    ptr_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (ptr_q >= count_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!scan_in_flight) begin
                    state_d     = S_IDLE;
                    scan_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (startStrobe && (state_q != S_IDLE) && (overrun_q != 16'hFFFF)) begin
            overrun_d = overrun_q + 16'd1;
        end

        if (grant[0] || scan_skip) begin
            ptr_d = ptr_q + count_t'(1);
        end
        if (grant[0]) begin
            addr_d   = ptr_q[FOFB_INDEX_WIDTH-1:0];
            tag_d[0] = '{valid: 1'b1, owner: OWN_SCAN, index: ptr_q[FOFB_INDEX_WIDTH-1:0]};
        end else if (grant[1]) begin
            addr_d        = cpu_addr_q;
            tag_d[0]      = '{valid: 1'b1, owner: OWN_CPU, index: cpu_addr_q};
            cpu_pending_d = 1'b0;
        end

        // The exiting tag lines up with the DPRAM data for the address granted two cycles ago.
        if (exit_tag.valid) begin
            if (exit_tag.owner == OWN_SCAN) begin
                scan_valid_d = 1'b1;
                scan_index_d = exit_tag.index;
                scan_x_d     = dpram.readoutX;
                scan_y_d     = dpram.readoutY;
                scan_s_d     = dpram.readoutS;
            end else begin
                cpu_ack_d  = 1'b1;
                cpu_busy_d = 1'b0;
                cpu_x_d    = dpram.readoutX;
                cpu_y_d    = dpram.readoutY;
                cpu_s_d    = dpram.readoutS;
            end
        end

        if (cpuReq && !cpu_busy_q) begin
            cpu_pending_d = 1'b1;
            cpu_busy_d    = 1'b1;
            cpu_addr_d    = cpuAddress;
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            count_q       <= '0;
            cpu_pending_q <= 1'b0;
            cpu_busy_q    <= 1'b0;
            cpu_addr_q    <= '0;
            addr_q        <= '0;
            scan_valid_q  <= 1'b0;
            scan_index_q  <= '0;
            scan_x_q      <= '0;
            scan_y_q      <= '0;
            scan_s_q      <= '0;
            scan_done_q   <= 1'b0;
            cpu_ack_q     <= 1'b0;
            cpu_x_q       <= '0;
            cpu_y_q       <= '0;
            cpu_s_q       <= '0;
            overrun_q     <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            cpu_pending_q <= cpu_pending_d;
            cpu_busy_q    <= cpu_busy_d;
            cpu_addr_q    <= cpu_addr_d;
            addr_q        <= addr_d;
            scan_valid_q  <= scan_valid_d;
            scan_index_q  <= scan_index_d;
            scan_x_q      <= scan_x_d;
            scan_y_q      <= scan_y_d;
            scan_s_q      <= scan_s_d;
            scan_done_q   <= scan_done_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_x_q       <= cpu_x_d;
            cpu_y_q       <= cpu_y_d;
            cpu_s_q       <= cpu_s_d;
            overrun_q     <= overrun_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign dpram.readoutAddress = addr_q;
    assign scanValid    = scan_valid_q;
    assign scanIndex    = scan_index_q;
    assign scanX        = scan_x_q;
    assign scanY        = scan_y_q;
    assign scanS        = scan_s_q;
    assign scanBusy     = (state_q != S_IDLE);
    assign scanDone     = scan_done_q;
    assign cpuAck       = cpu_ack_q;
    assign cpuX         = cpu_x_q;
    assign cpuY         = cpu_y_q;
    assign cpuS         = cpu_s_q;
    assign cpuBusy      = cpu_busy_q;
    assign overrunCount = overrun_q;

endmodule

// File: tb/tb_fofb_readout_scheduler.sv
// Bench for fofb_readout_scheduler: directed scenarios plus random traffic against a slot-level reference model.
// Define FOFB_READOUT_MASK_EN to also exercise the bpmMask feature.
module tb_fofb_readout_scheduler;
    import fofb_readout_pkg::*;

    localparam int W     = FOFB_INDEX_WIDTH;
    localparam int DEPTH = TABLE_DEPTH;

    logic           sysClk = 1'b0;
    logic           sysReset;
    logic           startStrobe;
    logic [W:0]     bpmCount;
`ifdef FOFB_READOUT_MASK_EN
    logic [DEPTH-1:0] bpmMask;
`endif
    logic           scanValid, scanBusy, scanDone, cpuReq, cpuAck, cpuBusy;
    logic [W-1:0]   scanIndex, cpuAddress;
    logic [31:0]    scanX, scanY, scanS, cpuX, cpuY, cpuS;
    logic [15:0]    overrunCount;

    fofb_readout_scheduler_if dp ();

    fofb_readout_scheduler dut (
        .sysClk       (sysClk),
        .sysReset     (sysReset),
        .startStrobe  (startStrobe),
        .bpmCount     (bpmCount),
`ifdef FOFB_READOUT_MASK_EN
        .bpmMask      (bpmMask),
`endif
        .dpram        (dp),
        .scanValid    (scanValid),
        .scanIndex    (scanIndex),
        .scanX        (scanX),
        .scanY        (scanY),
        .scanS        (scanS),
        .scanBusy     (scanBusy),
        .scanDone     (scanDone),
        .cpuReq       (cpuReq),
        .cpuAddress   (cpuAddress),
        .cpuAck       (cpuAck),
        .cpuX         (cpuX),
        .cpuY         (cpuY),
        .cpuS         (cpuS),
        .cpuBusy      (cpuBusy),
        .overrunCount (overrunCount)
    );

    always #5 sysClk = ~sysClk;

    logic [31:0] mem_x [DEPTH];
    logic [31:0] mem_y [DEPTH];
    logic [31:0] mem_s [DEPTH];

    // DPRAM with one clock of read latency
    always @(posedge sysClk) begin
        dp.readoutX <= mem_x[dp.readoutAddress];
        dp.readoutY <= mem_y[dp.readoutAddress];
        dp.readoutS <= mem_s[dp.readoutAddress];
    end

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        int due;
        bit is_cpu;
        int idx;
    } ev_t;
    ev_t evq[$];

    bit m_scan_busy, m_scanning, m_cpu_pending, m_cpu_busy, m_last_cpu;
    int m_ptr, m_cnt, m_last_scan_grant, m_done_at, m_cpu_addr, m_overrun;
    int e_scan_valid, e_scan_index, e_scan_x, e_scan_y, e_scan_s, e_scan_done;
    int e_cpu_ack, e_cpu_x, e_cpu_y, e_cpu_s, e_addr;

    int obs_beats, obs_first_beat, obs_last_beat, obs_first_index, obs_done, obs_dones;
    int obs_acks, obs_ack_cycle;

    function automatic bit idx_enabled(int i);
`ifdef FOFB_READOUT_MASK_EN
        return bpmMask[i];
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        evq.delete();
        m_scan_busy = 0; m_scanning = 0; m_cpu_pending = 0; m_cpu_busy = 0; m_last_cpu = 0;
        m_ptr = 0; m_cnt = 0; m_last_scan_grant = -100; m_done_at = -1; m_cpu_addr = 0; m_overrun = 0;
        e_scan_valid = 0; e_scan_index = 0; e_scan_x = 0; e_scan_y = 0; e_scan_s = 0; e_scan_done = 0;
        e_cpu_ack = 0; e_cpu_x = 0; e_cpu_y = 0; e_cpu_s = 0; e_addr = 0;
    endtask

    // One read slot per cycle; results appear three cycles after the slot is granted.
    task automatic model_step();
        int  n = cycle + 1;
        bit  scan_wants = 0;
        bit  take_start = 0;
        bit  g_scan, g_cpu;
        ev_t ev;
        if (sysReset) begin
            model_reset();
            return;
        end
        if (m_scanning) begin
            if (m_ptr >= m_cnt) begin
                m_scanning = 0;
                m_done_at  = ((cycle + 1 > m_last_scan_grant + 3) ? cycle + 1 : m_last_scan_grant + 3) + 1;
            end else if (!idx_enabled(m_ptr)) begin
                m_ptr++;
            end else begin
                scan_wants = 1;
            end
        end
        g_scan = scan_wants && (!m_cpu_pending || m_last_cpu);
        g_cpu  = m_cpu_pending && (!scan_wants || !m_last_cpu);
        if (g_scan) begin
            evq.push_back('{cycle + 3, 1'b0, m_ptr});
            e_addr = m_ptr;
            m_ptr++;
            m_last_scan_grant = cycle;
            m_last_cpu = 0;
        end
        if (g_cpu) begin
            evq.push_back('{cycle + 3, 1'b1, m_cpu_addr});
            e_addr = m_cpu_addr;
            m_cpu_pending = 0;
            m_last_cpu = 1;
        end
        if (startStrobe) begin
            if (m_scan_busy) begin
                if (m_overrun < 65535) m_overrun++;
            end else begin
                take_start = 1;
            end
        end
        if (cpuReq && !m_cpu_busy) begin
            m_cpu_pending = 1;
            m_cpu_busy    = 1;
            m_cpu_addr    = int'(cpuAddress);
        end
        e_scan_valid = 0; e_cpu_ack = 0; e_scan_done = 0;
        while (evq.size() > 0 && evq[0].due == n) begin
            ev = evq.pop_front();
            if (ev.is_cpu) begin
                e_cpu_ack = 1; m_cpu_busy = 0;
                e_cpu_x = mem_x[ev.idx]; e_cpu_y = mem_y[ev.idx]; e_cpu_s = mem_s[ev.idx];
            end else begin
                e_scan_valid = 1; e_scan_index = ev.idx;
                e_scan_x = mem_x[ev.idx]; e_scan_y = mem_y[ev.idx]; e_scan_s = mem_s[ev.idx];
            end
        end
        if (m_done_at == n) begin
            e_scan_done = 1;
            m_scan_busy = 0;
        end
        if (take_start) begin
            m_scan_busy = 1;
            m_scanning  = 1;
            m_ptr       = 0;
            m_cnt       = (int'(bpmCount) > DEPTH) ? DEPTH : int'(bpmCount);
        end
    endtask

    task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic clear_stats();
        obs_beats = 0; obs_first_beat = -1; obs_last_beat = -1; obs_first_index = -1;
        obs_done = -1; obs_dones = 0; obs_acks = 0; obs_ack_cycle = -1;
    endtask

    task automatic check_output();
        chk("scanValid", 32'(scanValid), e_scan_valid);
        chk("scanIndex", 32'(scanIndex), e_scan_index);
        chk("scanX", scanX, e_scan_x);
        chk("scanY", scanY, e_scan_y);
        chk("scanS", scanS, e_scan_s);
        chk("scanBusy", 32'(scanBusy), 32'(m_scan_busy));
        chk("scanDone", 32'(scanDone), e_scan_done);
        chk("cpuAck", 32'(cpuAck), e_cpu_ack);
        chk("cpuX", cpuX, e_cpu_x);
        chk("cpuY", cpuY, e_cpu_y);
        chk("cpuS", cpuS, e_cpu_s);
        chk("cpuBusy", 32'(cpuBusy), 32'(m_cpu_busy));
        chk("overrunCount", 32'(overrunCount), m_overrun);
        chk("readoutAddress", 32'(dp.readoutAddress), e_addr);
        if (scanValid) begin
            if (obs_beats == 0) begin
                obs_first_beat  = cycle;
                obs_first_index = int'(scanIndex);
            end
            obs_last_beat = cycle;
            obs_beats++;
        end
        if (scanDone) begin
            obs_done = cycle;
            obs_dones++;
        end
        if (cpuAck) begin
            obs_acks++;
            obs_ack_cycle = cycle;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge sysClk);
        #1;
        cycle++;
        check_output();
        startStrobe = 1'b0;
        cpuReq      = 1'b0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_stimulus(int count);
        bpmCount    = (W + 1)'(count);
        startStrobe = 1'b1;
    endtask

    int t0;

    initial begin
        sysReset = 1'b1; startStrobe = 1'b0; bpmCount = '0; cpuReq = 1'b0; cpuAddress = '0;
`ifdef FOFB_READOUT_MASK_EN
        bpmMask = '1;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            mem_x[i] = i; mem_y[i] = i + 100; mem_s[i] = i + 200;
        end
        model_reset();
        clear_stats();
        run(2);
        sysReset = 1'b0;
        run(2);

        // basic scan of 8 indices
        clear_stats(); t0 = cycle; apply_stimulus(8); run(15);
        chk("t1_beats", obs_beats, 8);
        chk("t1_first_beat", obs_first_beat - t0, 4);
        chk("t1_last_beat", obs_last_beat - t0, 11);
        chk("t1_done", obs_done - t0, 12);

        // CPU read of index 5 interleaved into the scan
        clear_stats(); t0 = cycle; apply_stimulus(8); run(2);
        cpuReq = 1'b1; cpuAddress = 9'd5; run(13);
        chk("t2_acks", obs_acks, 1);
        chk("t2_ack_cycle", obs_ack_cycle - t0, 6);
        chk("t2_cpuX", cpuX, 5);
        chk("t2_cpuY", cpuY, 105);
        chk("t2_cpuS", cpuS, 205);
        chk("t2_beats", obs_beats, 8);
        chk("t2_done", obs_done - t0, 13);

        // processor hammering the port during a scan
        clear_stats(); t0 = cycle; apply_stimulus(16);
        for (int i = 0; i < 40; i++) begin
            if (!m_cpu_busy) begin
                cpuReq = 1'b1; cpuAddress = W'($urandom_range(0, DEPTH - 1));
            end
            step();
        end
        run(8);
        chk("t3_beats", obs_beats, 16);
        chk("t3_done_seen", obs_dones, 1);
        chk("t3_cpu_acks_min", 32'(obs_acks >= 4), 1);

        // empty scan
        clear_stats(); t0 = cycle; apply_stimulus(0); run(6);
        chk("t4_beats", obs_beats, 0);
        chk("t4_done", obs_done - t0, 3);

        // start while busy counts an overrun and leaves the scan alone
        clear_stats(); t0 = cycle; apply_stimulus(8); run(3);
        apply_stimulus(3); run(12);
        chk("t5_overrun", 32'(overrunCount), 1);
        chk("t5_beats", obs_beats, 8);
        chk("t5_done", obs_done - t0, 12);

        // reset in the middle of a scan
        clear_stats(); t0 = cycle; apply_stimulus(8); run(7);
        chk("t6_pre_reset_index", 32'(scanIndex), 3);
        sysReset = 1'b1; step(); sysReset = 1'b0;
        chk("t6_reset_busy", 32'(scanBusy), 0);
        chk("t6_reset_overrun", 32'(overrunCount), 0);
        chk("t6_reset_x", scanX, 0);
        clear_stats(); run(12);
        chk("t6_no_done", obs_dones, 0);
        clear_stats(); apply_stimulus(4); run(10);
        chk("t6_restart_first_index", obs_first_index, 0);
        chk("t6_restart_beats", obs_beats, 4);

        // oversized count clamps to the full table
        clear_stats(); t0 = cycle; apply_stimulus(600); run(520);
        chk("t7_beats", obs_beats, DEPTH);
        chk("t7_first_beat", obs_first_beat - t0, 4);
        chk("t7_last_beat", obs_last_beat - t0, 515);
        chk("t7_done", obs_done - t0, 516);

`ifdef FOFB_READOUT_MASK_EN
        bpmMask = '1; bpmMask[7:0] = 8'b1010_0101;
        clear_stats(); t0 = cycle; apply_stimulus(8); run(15);
        chk("t8_beats", obs_beats, 4);
        chk("t8_done_after_last", obs_done - obs_last_beat, 1);
        for (int i = 0; i < DEPTH; i += 32) bpmMask[i +: 32] = $urandom();
`endif

        // random traffic
        for (int i = 0; i < DEPTH; i++) begin
            mem_x[i] = $urandom(); mem_y[i] = $urandom(); mem_s[i] = $urandom();
        end
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                apply_stimulus(($urandom_range(0, 9) == 0) ? $urandom_range(500, 600) : $urandom_range(0, 24));
            end
            if ($urandom_range(0, 2) == 0) begin
                cpuReq = 1'b1; cpuAddress = W'($urandom_range(0, DEPTH - 1));
            end
            sysReset = ($urandom_range(0, 799) == 0);
            step();
        end
        sysReset = 1'b0;
        run(700);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
